// File: rtl/inst_word_encoder.sv
// ---------------------------------------------------------------------------
// inst_word_encoder
//   Transmit-side packer for the instruction-word decoder bus. Field tuples
//   (comp, inst, operand) are accepted over a valid/ready handshake and packed
//   into a 32-bit word with a 4-bit sequence stamp and a nibble-XOR checksum.
//   Packed words are buffered in a small FIFO whose head is a registered
//   output. Tuples carrying the reserved inst code complete their handshake
//   but are dropped, and err_illegal pulses for one cycle.
//
//   Word layout: [31:26] comp, [25:23] inst, [22:8] operand, [7:4] seq,
//                [3:0] chk = XOR of the seven nibbles of word[31:4].
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     input tuple valid
//   in_ready     encoder can accept a tuple (FIFO not full, not in reset)
//   in_comp      6-bit comp field
//   in_inst      3-bit inst field
//   in_operand   15-bit operand payload
//   out_valid    out_word holds a packed word
//   out_ready    downstream accepts out_word
//   out_word     packed word (FIFO head, registered)
//   err_illegal  one-cycle pulse after a reserved-inst tuple was dropped
//   seq_now      sequence stamp the next stored word will carry
//   fifo_count   number of buffered words
// ---------------------------------------------------------------------------
module inst_word_encoder #(
    parameter int         DEPTH         = 2,
    parameter logic [2:0] RESERVED_INST = 3'b111
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [5:0]                in_comp,
    input  logic [2:0]                in_inst,
    input  logic [14:0]               in_operand,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_word,
    output logic                      err_illegal,
    output logic [3:0]                seq_now,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int             PW      = $clog2(DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  ONE_C   = CW'(1);
    localparam logic [CW-1:0]  ZERO_C  = CW'(0);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);

    // XOR of the seven nibbles of the word body (bits [31:4]).
    function automatic logic [3:0] calc_chk(input logic [27:0] body);
        logic [3:0] c;
        c = 4'h0;
        for (int i = 0; i < 7; i++) begin
            c = c ^ body[4*i +: 4];
        end
        return c;
    endfunction

    logic [31:0]    mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  rd_ptr_next;
    logic [CW-1:0]  count_after_pop;
    logic [CW-1:0]  count_next;
    logic [27:0]    new_body;
    logic [31:0]    new_word;
    logic [31:0]    head_next;
    logic           accept;
    logic           illegal;
    logic           push;
    logic           pop;

    // Handshake decode, word packing and next FIFO head selection.
    always_comb begin
        in_ready        = 1'b0;
        accept          = 1'b0;
        illegal         = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        new_body        = 28'h0;
        new_word        = 32'h0;
        count_after_pop = fifo_count;
        count_next      = fifo_count;
        rd_ptr_next     = rd_ptr;
        head_next       = out_word;

        // in_ready looks only at occupancy, never at out_ready.
        if (!rst && (fifo_count < DEPTH_C)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end

        accept   = in_valid && in_ready;
        illegal  = (in_inst == RESERVED_INST);
        push     = accept && !illegal;
        pop      = out_valid && out_ready;
        new_body = {in_comp, in_inst, in_operand, seq_now};
        new_word = {new_body, calc_chk(new_body)};

        if (pop) begin
            count_after_pop = fifo_count - ONE_C;
            rd_ptr_next     = rd_ptr + PTR_ONE;
        end else begin
            count_after_pop = fifo_count;
            rd_ptr_next     = rd_ptr;
        end

        if (push) begin
            count_next = count_after_pop + ONE_C;
        end else begin
            count_next = count_after_pop;
        end

        // The word being written this edge is not yet readable from mem, so
        // when it becomes the head it is forwarded directly.
        if (count_next == ZERO_C) begin
            head_next = out_word;
        end else if (count_after_pop == ZERO_C) begin
            head_next = new_word;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // FIFO storage, pointers, sequence counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= ZERO_C;
            seq_now     <= 4'h0;
            out_valid   <= 1'b0;
            out_word    <= 32'h0;
            err_illegal <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_word;
                wr_ptr      <= wr_ptr + PTR_ONE;
                seq_now     <= seq_now + 4'd1;
            end else begin
                wr_ptr      <= wr_ptr;
                seq_now     <= seq_now;
            end
            rd_ptr      <= rd_ptr_next;
            fifo_count  <= count_next;
            out_valid   <= (count_next != ZERO_C);
            out_word    <= head_next;
            err_illegal <= accept && illegal;
        end
    end

endmodule

// File: tb/tb_inst_word_encoder.sv
module tb_inst_word_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_comp;
    logic [2:0]  in_inst;
    logic [14:0] in_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        err_illegal;
    logic [3:0]  seq_now;
    logic [1:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    inst_word_encoder #(.DEPTH(2), .RESERVED_INST(3'b111)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_comp     (in_comp),
        .in_inst     (in_inst),
        .in_operand  (in_operand),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .err_illegal (err_illegal),
        .seq_now     (seq_now),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference packing from the field layout using plain arithmetic.
    function automatic logic [31:0] pack(input int comp, input int inst, input int op, input int seq);
        longint body;
        longint c;
        body = longint'(comp) * 64'd67108864 + longint'(inst) * 64'd8388608
             + longint'(op) * 64'd256 + longint'(seq % 16) * 64'd16;
        c = 0;
        for (int i = 1; i <= 7; i++) begin
            c = c ^ ((body / (64'd1 << (4 * i))) % 16);
        end
        return 32'(body + c);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive(input int comp, input int inst, input int op);
        in_comp    = 6'(comp);
        in_inst    = 3'(inst);
        in_operand = 15'(op);
    endtask

    typedef struct {
        int          comp;
        int          inst;
        int          op;
        logic        exp_err;
        logic [31:0] exp_word;
        logic [3:0]  exp_seq;
    } vec_t;

    vec_t vecs[7];
    logic [31:0] q[$];
    logic [31:0] wrd;
    int          seq_m;
    logic        err_m;
    logic        acc;
    logic        pop;

    initial begin
        vecs[0] = '{comp: 'h01, inst: 2, op: 'h0000, exp_err: 1'b0, exp_word: 32'h0500_0005, exp_seq: 4'd1};
        vecs[1] = '{comp: 'h01, inst: 2, op: 'h0000, exp_err: 1'b0, exp_word: 32'h0500_0014, exp_seq: 4'd2};
        vecs[2] = '{comp: 'h3F, inst: 0, op: 'h7FFF, exp_err: 1'b0, exp_word: 32'hFC7F_FF29, exp_seq: 4'd3};
        vecs[3] = '{comp: 'h15, inst: 7, op: 'h1234, exp_err: 1'b1, exp_word: 32'h0000_0000, exp_seq: 4'd3};
        vecs[4] = '{comp: 'h2A, inst: 5, op: 'h5555, exp_err: 1'b0, exp_word: 32'hAAD5_553B, exp_seq: 4'd4};
        vecs[5] = '{comp: 'h00, inst: 0, op: 'h0000, exp_err: 1'b0, exp_word: 32'h0000_0044, exp_seq: 4'd5};
        vecs[6] = '{comp: 'h3F, inst: 6, op: 'h0001, exp_err: 1'b0, exp_word: 32'hFF00_0154, exp_seq: 4'd6};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(0, 0, 0);
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_word", out_word, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_seq", 32'(seq_now), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Table vectors: one tuple per slot, out_ready high.
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(vecs[i].comp, vecs[i].inst, vecs[i].op);
            in_valid = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_err", i), 32'(err_illegal), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(!vecs[i].exp_err));
            check($sformatf("vec%0d_count", i), 32'(fifo_count), vecs[i].exp_err ? 32'd0 : 32'd1);
            check($sformatf("vec%0d_seq", i), 32'(seq_now), 32'(vecs[i].exp_seq));
            if (!vecs[i].exp_err) begin
                check($sformatf("vec%0d_word", i), out_word, vecs[i].exp_word);
                check($sformatf("vec%0d_model", i), out_word,
                      pack(vecs[i].comp, vecs[i].inst, vecs[i].op, int'(vecs[i].exp_seq) - 1));
            end
            @(negedge clk);
            check($sformatf("vec%0d_err_off", i), 32'(err_illegal), 32'd0);
            check($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Full FIFO backpressure: A, B accepted, C held until space frees.
        do_reset();
        out_ready = 1'b0;
        drive('h11, 1, 'h0AAA);
        in_valid = 1'b1;
        @(negedge clk);
        drive('h22, 3, 'h0BBB);
        @(negedge clk);
        drive('h33, 4, 'h0CCC);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(fifo_count), 32'd2);
        check("full_head", out_word, pack('h11, 1, 'h0AAA, 0));
        @(negedge clk);
        check("full_hold_word", out_word, pack('h11, 1, 'h0AAA, 0));
        check("full_hold_count", 32'(fifo_count), 32'd2);
        check("full_hold_seq", 32'(seq_now), 32'd2);
        out_ready = 1'b1;
        @(negedge clk);
        check("drain1_word", out_word, pack('h22, 3, 'h0BBB, 1));
        check("drain1_count", 32'(fifo_count), 32'd1);
        check("drain1_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("drain2_word", out_word, pack('h33, 4, 'h0CCC, 2));
        check("drain2_valid", 32'(out_valid), 32'd1);
        check("drain2_count", 32'(fifo_count), 32'd1);
        @(negedge clk);
        check("drain3_empty", 32'(out_valid), 32'd0);
        check("drain3_seq", 32'(seq_now), 32'd3);

        // Seventeen back-to-back pushes: stamps wrap to 0 on the 17th.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(i, i % 7, i * 1000);
            in_valid = 1'b1;
            @(negedge clk);
            check($sformatf("wrap%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("wrap%0d_word", i), out_word, pack(i, i % 7, i * 1000, i));
            wrd = out_word;
            check($sformatf("wrap%0d_stamp", i), 32'(wrd[7:4]), 32'(i % 16));
        end
        in_valid = 1'b0;
        check("wrap_seq_end", 32'(seq_now), 32'd1);

        // Asynchronous reset with two words buffered.
        do_reset();
        out_ready = 1'b0;
        drive('h05, 2, 'h0100);
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_arst_count", 32'(fifo_count), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_count", 32'(fifo_count), 32'd0);
        check("arst_seq", 32'(seq_now), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against a queue model.
        q = {};
        seq_m = 0;
        err_m = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            check("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
            check("rnd_count", 32'(fifo_count), 32'(q.size()));
            check("rnd_in_ready", 32'(in_ready), 32'(q.size() < 2));
            check("rnd_seq", 32'(seq_now), 32'(seq_m));
            check("rnd_err", 32'(err_illegal), 32'(err_m));
            if (q.size() != 0) begin
                check("rnd_word", out_word, q[0]);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            drive(int'($urandom_range(0, 63)), int'($urandom_range(0, 7)), int'($urandom_range(0, 32767)));
            acc = in_valid && (q.size() < 2);
            pop = (q.size() != 0) && out_ready;
            @(posedge clk);
            if (pop) begin
                void'(q.pop_front());
            end
            err_m = acc && (in_inst == 3'b111);
            if (acc && (in_inst != 3'b111)) begin
                q.push_back(pack(int'(in_comp), int'(in_inst), int'(in_operand), seq_m));
                seq_m = (seq_m + 1) % 16;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
